// File: rtl/dmem_arb_pkg.sv
// Shared definitions for the two-port data-memory arbiter: FSM encoding,
// port indices and address-check widths.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_DBG = 1'b1;

  // Low address bits that must be zero for a legal word access.
  localparam int ALIGN_W = 2;

endpackage

// File: rtl/dmem_arbiter_if.sv
// One requester port of the data-memory arbiter: held request in,
// one-cycle ack/err/rdata completion out.
interface dmem_arbiter_if #(
  parameter int DATA_W = 32
);
  logic              req;
  logic              we;
  logic [DATA_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              ack;
  logic              err;
  logic [DATA_W-1:0] rdata;

  modport master (output req, we, addr, wdata, input ack, err, rdata);
  modport slave  (input req, we, addr, wdata, output ack, err, rdata);
endinterface

// File: rtl/dmem_arbiter_rr_arb2.sv
// Two-way round-robin pick: a lone requester wins, a tie goes to the port
// that was not granted last.
module rr_arb2
  import dmem_arb_pkg::*;
(
  input  logic [1:0] req_i,
  input  logic       last_i,
  output logic       grant_o
);

  always_comb begin
    grant_o = PORT_CPU;
    case (req_i)
      2'b01:   grant_o = PORT_CPU;
      2'b10:   grant_o = PORT_DBG;
      2'b11:   grant_o = ~last_i;
      default: grant_o = PORT_CPU;
    endcase
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares one single-port data memory between a CPU port and a debug/DMA
// port; each access takes IDLE -> ACCESS -> DONE with registered strobes.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int DEPTH_WORDS = 64,
  parameter int DATA_W      = 32
) (
  input  logic              clk,
  input  logic              rst,
  dmem_arbiter_if.slave     p0,
  dmem_arbiter_if.slave     p1,
  output logic [DATA_W-1:0] mem_address_o,
  output logic [DATA_W-1:0] mem_write_data_o,
  output logic              mem_write_o,
  output logic              mem_read_o,
  input  logic [DATA_W-1:0] mem_read_data_i,
  output logic              busy_o
);

  function automatic logic addr_bad(input logic [DATA_W-1:0] a);
    logic [DATA_W-1:0] word_idx;
    word_idx = a >> ALIGN_W;
    return (a[ALIGN_W-1:0] != '0) || (word_idx >= DATA_W'(DEPTH_WORDS));
  endfunction

  state_e                 state_q;
  logic                   owner_q;
  logic                   we_q;
  logic                   bad_q;
  logic                   last_q;
  logic                   busy_q;
  logic                   mem_write_q;
  logic                   mem_read_q;
  logic [DATA_W-1:0]      mem_address_q;
  logic [DATA_W-1:0]      mem_write_data_q;
  logic [1:0]             ack_q;
  logic [1:0]             err_q;
  logic [1:0][DATA_W-1:0] rdata_q;

  logic [1:0]        req_s;
  logic              gnt_s;
  logic              sel_we_s;
  logic [DATA_W-1:0] sel_addr_s;
  logic [DATA_W-1:0] sel_wdata_s;
  logic              sel_bad_s;

  assign req_s       = {p1.req, p0.req};
  assign sel_we_s    = (gnt_s == PORT_DBG) ? p1.we    : p0.we;
  assign sel_addr_s  = (gnt_s == PORT_DBG) ? p1.addr  : p0.addr;
  assign sel_wdata_s = (gnt_s == PORT_DBG) ? p1.wdata : p0.wdata;
  assign sel_bad_s   = addr_bad(sel_addr_s);

  rr_arb2 u_rr_arb2 (
    .req_i   (req_s),
    .last_i  (last_q),
    .grant_o (gnt_s)
  );

  // Access sequencer: latches the winner in IDLE, strobes memory for one
  // cycle, then pulses the owner's ack and records it as last granted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q          <= ST_IDLE;
      owner_q          <= PORT_CPU;
      we_q             <= 1'b0;
      bad_q            <= 1'b0;
      last_q           <= PORT_DBG;
      busy_q           <= 1'b0;
      mem_write_q      <= 1'b0;
      mem_read_q       <= 1'b0;
      mem_address_q    <= '0;
      mem_write_data_q <= '0;
      ack_q            <= 2'b00;
      err_q            <= 2'b00;
      rdata_q          <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          ack_q <= 2'b00;
          err_q <= 2'b00;
          if (|req_s) begin
            owner_q          <= gnt_s;
            we_q             <= sel_we_s;
            bad_q            <= sel_bad_s;
            mem_address_q    <= sel_addr_s;
            mem_write_data_q <= sel_wdata_s;
            mem_write_q      <= sel_we_s & ~sel_bad_s;
            mem_read_q       <= ~sel_we_s & ~sel_bad_s;
            busy_q           <= 1'b1;
            state_q          <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          mem_write_q <= 1'b0;
          mem_read_q  <= 1'b0;
          // Only a successful read updates the owner's read data.
          if (!we_q && !bad_q) begin
            rdata_q[owner_q] <= mem_read_data_i;
          end
          ack_q[owner_q] <= 1'b1;
          err_q[owner_q] <= bad_q;
          state_q        <= ST_DONE;
        end
        ST_DONE: begin
          ack_q   <= 2'b00;
          err_q   <= 2'b00;
          last_q  <= owner_q;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          mem_write_q <= 1'b0;
          mem_read_q  <= 1'b0;
          ack_q       <= 2'b00;
          err_q       <= 2'b00;
          busy_q      <= 1'b0;
          state_q     <= ST_IDLE;
        end
      endcase
    end
  end

  assign mem_address_o    = mem_address_q;
  assign mem_write_data_o = mem_write_data_q;
  assign mem_write_o      = mem_write_q;
  assign mem_read_o       = mem_read_q;
  assign busy_o           = busy_q;

  assign p0.ack   = ack_q[0];
  assign p0.err   = err_q[0];
  assign p0.rdata = rdata_q[0];
  assign p1.ack   = ack_q[1];
  assign p1.err   = err_q[1];
  assign p1.rdata = rdata_q[1];

endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomized and directed bench for dmem_arbiter: requests are queued per
// port and a monitor scores every ack against a word-array memory model.
module tb_dmem_arbiter;

  localparam int DEPTH = 64;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } txn_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] mem_address;
  logic [31:0] mem_write_data;
  logic        mem_write;
  logic        mem_read;
  logic [31:0] mem_read_data;
  logic        busy;

  dmem_arbiter_if #(.DATA_W(32)) p0_if ();
  dmem_arbiter_if #(.DATA_W(32)) p1_if ();

  dmem_arbiter #(.DEPTH_WORDS(DEPTH), .DATA_W(32)) dut (
    .clk              (clk),
    .rst              (rst),
    .p0               (p0_if),
    .p1               (p1_if),
    .mem_address_o    (mem_address),
    .mem_write_data_o (mem_write_data),
    .mem_write_o      (mem_write),
    .mem_read_o       (mem_read),
    .mem_read_data_i  (mem_read_data),
    .busy_o           (busy)
  );

  always #5 clk = ~clk;

  logic [31:0] tb_mem  [DEPTH];
  logic [31:0] ref_mem [DEPTH];
  logic [31:0] exp_rdata [2];
  txn_t        q0 [$];
  txn_t        q1 [$];
  int          ack_order [$];
  logic        busy_log [8192];
  int          n_checks = 0;
  int          n_fails = 0;
  int          cyc = 0;
  int          strobe_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // The physical memory the arbiter drives.
  assign mem_read_data = ((mem_address >> 2) < 32'(DEPTH)) ? tb_mem[6'(mem_address >> 2)] : 32'h0;
  always @(posedge clk) begin
    if (mem_write && ((mem_address >> 2) < 32'(DEPTH))) tb_mem[6'(mem_address >> 2)] <= mem_write_data;
  end

  function automatic logic is_bad(input logic [31:0] a);
    return ((a % 32'd4) != 32'd0) || ((a / 32'd4) >= 32'(DEPTH));
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    chk(name, {31'b0, act}, {31'b0, exp});
  endtask

  task automatic score(input int n, input logic ack, input logic err);
    txn_t t;
    logic bad;
    int   w;
    if (!ack) begin
      chk1(n == 0 ? "p0_err_without_ack" : "p1_err_without_ack", err, 1'b0);
      return;
    end
    if ((n == 0 && q0.size() == 0) || (n == 1 && q1.size() == 0)) begin
      n_checks++;
      n_fails++;
      $display("FAIL unexpected_ack: port %0d acked with no outstanding request (cycle %0d)", n, cyc);
      return;
    end
    t   = (n == 0) ? q0.pop_front() : q1.pop_front();
    bad = is_bad(t.addr);
    w   = int'(t.addr / 32'd4);
    chk1(n == 0 ? "p0_err" : "p1_err", err, bad);
    if (!bad) begin
      if (t.we) ref_mem[w] = t.wdata;
      else      exp_rdata[n] = ref_mem[w];
    end
  endtask

  // Monitor: protocol checks every cycle, scoreboard on each ack.
  always @(negedge clk) begin
    busy_log[13'(cyc)] = busy;
    if (!rst) begin
      chk1("strobes_exclusive", mem_write & mem_read, 1'b0);
      if (mem_write || mem_read) begin
        strobe_cnt++;
        chk1("strobe_addr_legal", is_bad(mem_address), 1'b0);
      end
      chk1("ack_overlap", p0_if.ack & p1_if.ack, 1'b0);
      if (p0_if.ack) ack_order.push_back(0);
      if (p1_if.ack) ack_order.push_back(1);
      score(0, p0_if.ack, p0_if.err);
      score(1, p1_if.ack, p1_if.err);
      chk("p0_rdata", p0_if.rdata, exp_rdata[0]);
      chk("p1_rdata", p1_if.rdata, exp_rdata[1]);
    end
  end

  task automatic set_port(input int n, input logic req, input logic we,
                          input logic [31:0] addr, input logic [31:0] wdata);
    if (n == 0) begin
      p0_if.req = req; p0_if.we = we; p0_if.addr = addr; p0_if.wdata = wdata;
    end else begin
      p1_if.req = req; p1_if.we = we; p1_if.addr = addr; p1_if.wdata = wdata;
    end
  endtask

  task automatic issue(input int n, input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, input bit hold,
                       output int c_issue, output int c_ack);
    txn_t t;
    bit   got;
    @(posedge clk); #1;
    t.we = we; t.addr = addr; t.wdata = wdata;
    set_port(n, 1'b1, we, addr, wdata);
    if (n == 0) q0.push_back(t);
    else        q1.push_back(t);
    c_issue = cyc;
    got = 1'b0;
    for (int i = 0; i < 30 && !got; i++) begin
      @(negedge clk);
      got = (n == 0) ? p0_if.ack : p1_if.ack;
    end
    c_ack = cyc;
    if (!got) begin
      n_checks++;
      n_fails++;
      $display("FAIL ack_timeout: port %0d no ack within 30 cycles (cycle %0d)", n, cyc);
    end
    if (!hold) begin
      @(posedge clk); #1;
      set_port(n, 1'b0, 1'b0, 32'h0, 32'h0);
    end
  endtask

  task automatic rand_driver(input int n, input int count);
    int d, dn, ci, ca, r;
    logic [31:0] a;
    d = $urandom_range(0, 3);
    for (int i = 0; i < count; i++) begin
      repeat (d) @(posedge clk);
      dn = $urandom_range(0, 3);
      r  = $urandom_range(0, 9);
      if (r == 0)      a = (32'($urandom_range(0, 63)) << 2) + 32'($urandom_range(1, 3));
      else if (r == 1) a = 32'(DEPTH + $urandom_range(0, 200)) << 2;
      else             a = 32'($urandom_range(0, 63)) << 2;
      issue(n, 1'($urandom_range(0, 1)), a, $urandom, (dn == 0) && (i < count - 1), ci, ca);
      d = dn;
    end
  endtask

  task automatic clear_model();
    q0.delete();
    q1.delete();
    exp_rdata[0] = 32'h0;
    exp_rdata[1] = 32'h0;
  endtask

  int ci0, ca0, ci1, ca1, c_first, s0;

  initial begin
    rst = 1'b1;
    set_port(0, 1'b0, 1'b0, 32'h0, 32'h0);
    set_port(1, 1'b0, 1'b0, 32'h0, 32'h0);
    for (int i = 0; i < DEPTH; i++) begin
      tb_mem[i]  = 32'hA500_0000 | 32'(i);
      ref_mem[i] = 32'hA500_0000 | 32'(i);
    end
    clear_model();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_mem_write", mem_write, 1'b0);
    chk1("rst_mem_read", mem_read, 1'b0);
    chk("rst_mem_address", mem_address, 32'h0);
    chk("rst_mem_wdata", mem_write_data, 32'h0);
    chk1("rst_p0_ack", p0_if.ack, 1'b0);
    chk1("rst_p1_ack", p1_if.ack, 1'b0);
    chk("rst_p0_rdata", p0_if.rdata, 32'h0);
    chk("rst_p1_rdata", p1_if.rdata, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Write via p0 then read back via p1.
    issue(0, 1'b1, 32'h10, 32'hDEAD_BEEF, 1'b0, ci0, ca0);
    chk("p0_write_latency", 32'(ca0 - ci0), 32'd2);
    issue(1, 1'b0, 32'h10, 32'h0, 1'b0, ci1, ca1);
    chk("p1_read_latency", 32'(ca1 - ci1), 32'd2);
    chk("p1_readback", p1_if.rdata, 32'hDEAD_BEEF);

    // Contention: both held for four accesses alternate.
    ack_order.delete();
    fork
      begin
        issue(0, 1'b0, 32'h04, 32'h0, 1'b1, ci0, ca0);
        issue(0, 1'b1, 32'h08, 32'hCAFE_0008, 1'b0, ci0, ca0);
      end
      begin
        issue(1, 1'b1, 32'h0C, 32'h1111_000C, 1'b1, ci1, ca1);
        issue(1, 1'b0, 32'h08, 32'h0, 1'b0, ci1, ca1);
      end
    join
    chk("rr_ack_count", 32'(ack_order.size()), 32'd4);
    for (int i = 0; i < 4 && i < ack_order.size(); i++)
      chk("rr_order", 32'(ack_order[i]), 32'(i % 2));

    // Misaligned and out-of-range reads never strobe memory.
    s0 = strobe_cnt;
    issue(1, 1'b0, 32'h102, 32'h0, 1'b0, ci1, ca1);
    chk("err_misaligned_latency", 32'(ca1 - ci1), 32'd2);
    issue(1, 1'b0, 32'h100, 32'h0, 1'b0, ci1, ca1);
    chk("err_range_latency", 32'(ca1 - ci1), 32'd2);
    chk("err_no_strobes", 32'(strobe_cnt - s0), 32'd0);

    // Back-to-back reads with req held throughout.
    issue(0, 1'b0, 32'h00, 32'h0, 1'b1, ci0, ca0);
    c_first = ci0;
    chk("b2b_ack0", 32'(ca0 - c_first), 32'd2);
    issue(0, 1'b0, 32'h04, 32'h0, 1'b1, ci0, ca0);
    chk("b2b_ack1", 32'(ca0 - c_first), 32'd5);
    issue(0, 1'b0, 32'h08, 32'h0, 1'b0, ci0, ca0);
    chk("b2b_ack2", 32'(ca0 - c_first), 32'd8);
    for (int k = 1; k <= 8; k++)
      chk1("b2b_busy", busy_log[13'(c_first + k)], (k != 3) && (k != 6));

    // Reset during the ACCESS of a write aborts it without an ack.
    issue(1, 1'b1, 32'h20, 32'h1234_5678, 1'b0, ci1, ca1);
    @(posedge clk); #1;
    set_port(0, 1'b1, 1'b1, 32'h20, 32'h0000_0055);
    @(posedge clk); #2;
    chk1("abort_write_strobe", mem_write, 1'b1);
    rst = 1'b1;
    #1;
    chk1("abort_write_dropped", mem_write, 1'b0);
    chk1("abort_busy_dropped", busy, 1'b0);
    clear_model();
    set_port(0, 1'b0, 1'b0, 32'h0, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk1("abort_no_ack", p0_if.ack, 1'b0);
    end
    issue(0, 1'b0, 32'h20, 32'h0, 1'b0, ci0, ca0);
    chk("abort_prior_value", p0_if.rdata, 32'h1234_5678);

    // Randomized traffic from both ports.
    fork
      rand_driver(0, 60);
      rand_driver(1, 60);
    join
    repeat (4) @(posedge clk);
    chk("drain_q0", 32'(q0.size()), 32'd0);
    chk("drain_q1", 32'(q1.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter DEPTH_WORDS, default 64, data memory depth in 32-bit words.
REQ-002 Parameter DATA_W, default 32, data and address width.
REQ-003 The block SHALL have one clock and one reset; reset is asynchronous and active-high.
REQ-004 CLK  in  1  system clock, all state on rising edge.
REQ-005 RST  in  1  asynchronous active-high reset.
REQ-006 pN_req  in  1  port N (N=0 CPU, N=1 debug/DMA) access request, held until pN_ack.
REQ-007 pN_we  in  1  1=write, 0=read; stable while pN_req high.
REQ-008 pN_addr  in  32  byte address; stable while pN_req high.
REQ-009 pN_wdata  in  32  write data; stable while pN_req high.
REQ-010 pN_ack  out  1  one-cycle completion pulse.
REQ-011 pN_err  out  1  error qualifier, valid only with pN_ack.
REQ-012 pN_rdata  out  32  read data, valid with pN_ack on a successful read.
REQ-013 mem_address, mem_write_data  out  32  each, registered, drive the data memory.
REQ-014 mem_write, mem_read  out  1  memory strobes, never both high.
REQ-015 mem_read_data  in  32  memory read data.
REQ-016 busy  out  1  high in any state other than IDLE.

Function
REQ-017 The FSM SHALL have the states IDLE, ACCESS and DONE.
REQ-018 IDLE: if any pN_req is high, the FSM SHALL latch the winner's owner, we, addr and wdata into registers and go to ACCESS; otherwise it SHALL stay in IDLE.
REQ-019 Arbitration: a single requester wins; if both request, the port not granted most recently wins (round-robin).
REQ-020 ACCESS lasts exactly one cycle: mem_address = latched addr; mem_write = latched we; mem_read = !latched we; then go to DONE.
REQ-021 On the edge ending ACCESS, the block SHALL capture mem_read_data into the owner's rdata register, and the write commits in memory on the same edge.
REQ-022 DONE lasts one cycle: owner's pN_ack=1, then go to IDLE and record the owner as last-granted.
REQ-023 Latency: req high in cycle 0 (IDLE) -> strobe in cycle 1 -> ack in cycle 2; peak throughput is one access per 3 cycles.
REQ-024 A requester that still holds req in the cycle after its ack is a new request and SHALL be arbitrated normally.
REQ-025 An access is an error if addr[1:0] != 0 or addr[DATA_W-1:2] >= DEPTH_WORDS.
REQ-026 An error access SHALL pass through ACCESS with both strobes low, then ack with pN_err=1; pN_rdata is unchanged.
REQ-027 The non-owner's ack and err SHALL remain 0, and the non-owner's rdata SHALL hold its value.
REQ-028 mem_read and mem_write SHALL be 0 outside ACCESS.
REQ-029 Request changes during ACCESS or DONE SHALL have no effect on the access in flight.

Reset
REQ-030 RST SHALL force asynchronously: state=IDLE, all strobes, acks, errs and busy=0, all rdata=0, mem_address=mem_write_data=0, and last-granted=port 1, so port 0 wins the first tie.
REQ-031 Reset asserted during ACCESS SHALL drop mem_write immediately, so no write commits, and no ack is issued for the aborted access.

Structure
REQ-032 Shared package dmem_arb_pkg SHALL hold the state encoding, the port index constants (PORT_CPU=0, PORT_DBG=1) and the error-check width constants.
REQ-033 A sub-module rr_arb2 SHALL hold the 2-way round-robin pick (inputs: req[1:0], last; output: grant index).

Verification
REQ-034 Write via p0 (addr 0x10, data 0xDEADBEEF), then read via p1 from 0x10 -> p1_rdata=0xDEADBEEF, each ack 2 cycles after req, err=0.
REQ-035 Both ports request in the same cycle, held, for 4 accesses -> grants in order p0, p1, p0, p1; no ack overlap.
REQ-036 p1 reads addr 0x102 (misaligned) and then addr 0x100 (word 64, out of range) -> each gives p1_ack with p1_err=1, mem strobes never high.
REQ-037 RST pulsed during the ACCESS of a p0 write of 0x55 to 0x20 -> no p0_ack; a later read of 0x20 returns the prior value.
REQ-038 p0 holds req continuously across 3 reads -> acks in cycles 2, 5 and 8; busy low only in cycles 3 and 6.
